usb_rx_phy: RTL and testbench
=============================

Name: usb_rx_phy

Overview:
Full-speed (12 Mb/s) USB receive front end between the usb_d_p/usb_d_n pins and the packet decoder inside the usb block.
- Synchronises the raw differential pair to clk48 and recovers bit timing with a 4x-oversampling digital PLL.
- NRZI-decodes and bit-unstuffs the stream, detects SYNC and EOP, and delivers whole bytes LSB-first.
- Also reports line state and USB bus reset (long SE0).

Parameters:
CLK_PER_BIT, 4, clk48 cycles per bit; the phase counter counts 0..CLK_PER_BIT-1.
SAMPLE_PHASE, 2, phase-counter value at which a bit is sampled (mid-bit).
RESET_CYCLES, 120, consecutive SE0 clk48 cycles before bus_reset asserts (2.5 us).

Ports:
clk48  input  1  48 MHz clock; all logic on its rising edge.
rst_n  input  1  asynchronous active-low reset.
usb_d_p  input  1  raw D+ pin, asynchronous.
usb_d_n  input  1  raw D- pin, asynchronous.
rx_data  output  8  last assembled byte; held until the next byte completes.
rx_valid  output  1  one-cycle strobe: rx_data holds a new byte.
rx_active  output  1  high from SYNC detection to EOP or error.
rx_error  output  1  one-cycle strobe: bit-stuff error, SE1, or EOP not on a byte boundary.
bus_reset  output  1  high while SE0 has persisted for at least RESET_CYCLES.
line_state  output  2  synchronised line: 00 SE0, 01 J (dp=1, dn=0), 10 K (dp=0, dn=1), 11 SE1.

Behaviour:
- Reset values:
  - rx_data=0, rx_valid=0, rx_active=0, rx_error=0, bus_reset=0.
  - line_state=01 (J); synchroniser flops reset to dp=1, dn=0.
  - FSM=IDLE, all counters 0.
- Synchronisation: two flops per pin. line_state is the second-stage value, so it lags the pins by 2 cycles.
- Clock recovery:
  - Phase counter increments every cycle and wraps CLK_PER_BIT-1 -> 0.
  - Any change of line_state forces the counter to 0 on the next cycle.
  - Sample tick = counter==SAMPLE_PHASE. A bit period of 3..5 cycles must still decode correctly.
- NRZI decode at each sample tick:
  - bit=1 if the sampled J/K level equals the previous sampled level, else bit=0.
  - The previous level is reset to J.
- FSM states: IDLE, SYNC, DATA, ERR.
  - IDLE: the first sampled K enters SYNC and clears the one-counter.
  - SYNC: accepts decoded 0s. The first decoded 1 after at least 3 zeros (KK at the end of KJKJ..KK) enters DATA with the bit counter at 0 and asserts rx_active on the next cycle. A decoded 1 after fewer zeros, or SE0/SE1, returns to IDLE with no error.
  - DATA, data bits: shifted into the byte register LSB-first. The ones-counter counts consecutive 1s and resets on a 0.
  - DATA, stuffing: after six 1s the next bit is a stuff bit. A 0 is discarded (no shift, counter cleared). A 1 gives rx_error pulse -> ERR.
  - DATA, byte complete: on the 8th data bit rx_data is loaded and rx_valid pulses for one cycle, the cycle after that sample tick.
  - DATA, EOP: a sampled SE0 marks EOP. On the first subsequent sampled J, rx_active drops and the FSM returns to IDLE. If the bit counter is not 0 at EOP, the partial byte is dropped and rx_error pulses once.
  - DATA, SE1: a sampled SE1 gives rx_error pulse -> ERR.
  - ERR: rx_active=0. Returns to IDLE after 8 consecutive sampled J or after an SE0->J EOP.
- Bus reset: an SE0 counter counts every cycle line_state==00 and saturates at RESET_CYCLES.
  - bus_reset is high while the count is saturated and line_state==00.
  - It drops on the cycle after line_state leaves 00.
  - Assertion of bus_reset forces the FSM to IDLE and rx_active=0 without an rx_error.
- Simultaneous events: bus_reset overrides everything. Byte completion together with a stuff-error check: the byte's rx_valid is still issued. rx_error and rx_valid never pulse in the same cycle for the same bit.
- rst_n assertion mid-packet: immediate return to reset values; no strobes.

Test Plan:
1. Hold rst_n low with pins toggling -> all outputs at reset values, line_state=01. Release -> no rx_valid/rx_error for 100 cycles of J.
2. SE0 for 480 cycles, then J -> bus_reset high exactly RESET_CYCLES+2 cycles after SE0 onset at the pins; low 3 cycles after J at the pins; rx_active stays 0.
3. SYNC (KJKJKJKK), byte 0xA5, SE0 for 2 bits, J, at 4 cycles/bit -> rx_active high after SYNC; one rx_valid with rx_data=0xA5; rx_active low after J; rx_error never high.
4. Bytes 0xFF, 0x00 with a stuffed 0 after the 6th one -> exactly two rx_valid pulses, 0xFF then 0x00; no error.
5. Seven consecutive decoded 1s in DATA (no stuff bit) -> one rx_error pulse; rx_active low; no rx_valid for that byte; next valid SYNC+0x3C is received correctly.
6. Byte 0x5A with bit periods alternating 3 and 5 cycles, then EOP after 12 data bits -> rx_data=0x5A once; rx_error pulses once at EOP.

Source files
------------

// File: rtl/usb_rx_phy_if.sv
// Bundle of USB pad inputs and the decoded receive stream presented to the packet decoder.
interface usb_rx_phy_if;
    logic       usb_d_p;
    logic       usb_d_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_error;
    logic       bus_reset;
    logic [1:0] line_state;

    modport master (
        input  usb_d_p, usb_d_n,
        output rx_data, rx_valid, rx_active, rx_error, bus_reset, line_state
    );

    modport slave (
        output usb_d_p, usb_d_n,
        input  rx_data, rx_valid, rx_active, rx_error, bus_reset, line_state
    );
endinterface

// File: rtl/usb_rx_phy.sv
// Full-speed USB receive front end: pin synchroniser, 4x oversampling bit recovery,
// NRZI decode, bit unstuffing, SYNC/EOP framing and bus-reset detection.
module usb_rx_phy #(
    parameter int CLK_PER_BIT  = 4,
    parameter int SAMPLE_PHASE = 2,
    parameter int RESET_CYCLES = 120
) (
    input  logic         clk48,
    input  logic         rst_n,
    usb_rx_phy_if.master bus
);
    localparam int PH_W  = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int SE0_W = $clog2(RESET_CYCLES + 1);
    localparam logic [PH_W-1:0]  PH_MAX   = PH_W'(CLK_PER_BIT - 1);
    localparam logic [PH_W-1:0]  PH_SAMP  = PH_W'(SAMPLE_PHASE);
    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_ZERO  = PH_W'(0);
    localparam logic [SE0_W-1:0] SE0_MAX  = SE0_W'(RESET_CYCLES);
    localparam logic [SE0_W-1:0] SE0_ONE  = SE0_W'(1);
    localparam logic [SE0_W-1:0] SE0_ZERO = SE0_W'(0);

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } state_t;

    logic             dp_meta_r, dn_meta_r, dp_sync_r, dn_sync_r;
    logic [PH_W-1:0]  phase_r;
    logic [SE0_W-1:0] se0_cnt_r;
    logic [SE0_W-1:0] se0_cnt_next_s;
    logic             bus_reset_r;
    logic             bus_reset_set_s;
    state_t           state_r;
    logic             prev_k_r;
    logic [2:0]       bit_cnt_r;
    logic [2:0]       ones_cnt_r;
    logic [7:0]       shift_r;
    logic [7:0]       shift_next_s;
    logic             eop_r;
    logic [7:0]       rx_data_r;
    logic             rx_valid_r, rx_active_r, rx_error_r;
    logic [1:0]       ls_s, ls_next_s;
    logic             tick_s, is_jk_s, bit_s;

    assign ls_s         = {dn_sync_r, dp_sync_r};
    assign ls_next_s    = {dn_meta_r, dp_meta_r};
    assign tick_s       = (phase_r == PH_SAMP);
    assign is_jk_s      = (ls_s == LS_J) || (ls_s == LS_K);
    assign bit_s        = ((ls_s == LS_K) == prev_k_r);
    assign shift_next_s = {bit_s, shift_r[7:1]};

    // Two-flop synchroniser per pin; idles at J.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            dp_meta_r <= 1'b1;
            dn_meta_r <= 1'b0;
            dp_sync_r <= 1'b1;
            dn_sync_r <= 1'b0;
        end else begin
            dp_meta_r <= bus.usb_d_p;
            dn_meta_r <= bus.usb_d_n;
            dp_sync_r <= dp_meta_r;
            dn_sync_r <= dn_meta_r;
        end
    end

    // Bit-phase counter; it reads zero in the first cycle a new line level is visible.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= PH_ZERO;
        end else if (ls_next_s != ls_s) begin
            phase_r <= PH_ZERO;
        end else if (phase_r == PH_MAX) begin
            phase_r <= PH_ZERO;
        end else begin
            phase_r <= phase_r + PH_ONE;
        end
    end

    // Saturating SE0 duration count.
    always_comb begin
        se0_cnt_next_s = SE0_ZERO;
        if (ls_s != LS_SE0) begin
            se0_cnt_next_s = SE0_ZERO;
        end else if (se0_cnt_r == SE0_MAX) begin
            se0_cnt_next_s = se0_cnt_r;
        end else begin
            se0_cnt_next_s = se0_cnt_r + SE0_ONE;
        end
    end

    assign bus_reset_set_s = (ls_s == LS_SE0) && (se0_cnt_next_s == SE0_MAX);

    // Bus-reset detector state.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            se0_cnt_r   <= SE0_ZERO;
            bus_reset_r <= 1'b0;
        end else begin
            se0_cnt_r   <= se0_cnt_next_s;
            bus_reset_r <= bus_reset_set_s;
        end
    end

    // Receive framing FSM: SYNC hunt, data/unstuff, EOP and error recovery.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            prev_k_r    <= 1'b0;
            bit_cnt_r   <= 3'd0;
            ones_cnt_r  <= 3'd0;
            shift_r     <= 8'h00;
            eop_r       <= 1'b0;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            rx_active_r <= 1'b0;
            rx_error_r  <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            rx_error_r <= 1'b0;
            if (bus_reset_set_s) begin
                state_r     <= IDLE;
                rx_active_r <= 1'b0;
                eop_r       <= 1'b0;
                bit_cnt_r   <= 3'd0;
                ones_cnt_r  <= 3'd0;
            end else if (tick_s) begin
                if (is_jk_s) begin
                    prev_k_r <= (ls_s == LS_K);
                end
                case (state_r)
                    IDLE: begin
                        if (ls_s == LS_K) begin
                            state_r    <= SYNC;
                            ones_cnt_r <= 3'd0;
                            bit_cnt_r  <= 3'd0;
                        end
                    end
                    SYNC: begin
                        // bit_cnt_r counts SYNC zeros here, saturating at 7.
                        if (!is_jk_s) begin
                            state_r <= IDLE;
                        end else if (!bit_s) begin
                            if (bit_cnt_r != 3'd7) begin
                                bit_cnt_r <= bit_cnt_r + 3'd1;
                            end
                        end else if (bit_cnt_r >= 3'd3) begin
                            state_r     <= DATA;
                            bit_cnt_r   <= 3'd0;
                            ones_cnt_r  <= 3'd0;
                            eop_r       <= 1'b0;
                            rx_active_r <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    DATA: begin
                        if (eop_r) begin
                            if (ls_s == LS_J) begin
                                state_r     <= IDLE;
                                rx_active_r <= 1'b0;
                                eop_r       <= 1'b0;
                            end
                        end else if (ls_s == LS_SE1) begin
                            rx_error_r  <= 1'b1;
                            rx_active_r <= 1'b0;
                            state_r     <= ERR;
                            bit_cnt_r   <= 3'd0;
                        end else if (ls_s == LS_SE0) begin
                            eop_r <= 1'b1;
                            if (bit_cnt_r != 3'd0) begin
                                rx_error_r <= 1'b1;
                            end
                        end else if (ones_cnt_r == 3'd6) begin
                            if (bit_s) begin
                                rx_error_r  <= 1'b1;
                                rx_active_r <= 1'b0;
                                state_r     <= ERR;
                                bit_cnt_r   <= 3'd0;
                            end else begin
                                ones_cnt_r <= 3'd0;
                            end
                        end else begin
                            shift_r    <= shift_next_s;
                            ones_cnt_r <= bit_s ? (ones_cnt_r + 3'd1) : 3'd0;
                            bit_cnt_r  <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                rx_data_r  <= shift_next_s;
                                rx_valid_r <= 1'b1;
                            end
                        end
                    end
                    ERR: begin
                        // bit_cnt_r counts consecutive J samples here.
                        if (ls_s == LS_SE0) begin
                            eop_r     <= 1'b1;
                            bit_cnt_r <= 3'd0;
                        end else if (ls_s == LS_J) begin
                            if (eop_r || (bit_cnt_r == 3'd7)) begin
                                state_r   <= IDLE;
                                eop_r     <= 1'b0;
                                bit_cnt_r <= 3'd0;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 3'd1;
                            end
                        end else begin
                            bit_cnt_r <= 3'd0;
                            eop_r     <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.rx_data    = rx_data_r;
    assign bus.rx_valid   = rx_valid_r;
    assign bus.rx_active  = rx_active_r;
    assign bus.rx_error   = rx_error_r;
    assign bus.bus_reset  = bus_reset_r;
    assign bus.line_state = ls_s;
endmodule

// File: tb/tb_usb_rx_phy.sv
// Randomised scoreboard bench for usb_rx_phy: a line-level transmitter model feeds the
// pins while a monitor pops expected bytes/errors whenever the receiver strobes.
module tb_usb_rx_phy;
    localparam int RESET_CYCLES = 120;

    logic clk48 = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk48 = ~clk48;

    usb_rx_phy_if u ();

    usb_rx_phy #(.CLK_PER_BIT(4), .SAMPLE_PHASE(2), .RESET_CYCLES(RESET_CYCLES)) dut (
        .clk48 (clk48),
        .rst_n (rst_n),
        .bus   (u.master)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  mon_ev;
    int   checks = 0;
    int   errors = 0;
    bit   saw_active = 1'b0;
    bit   alt_mode = 1'b0;
    bit   alt_ph = 1'b0;
    logic cur_k = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        ev_t e;
        e.is_err = 1'b0;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        ev_t e;
        e.is_err = 1'b1;
        e.data   = 8'h00;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk48) begin
        if (rst_n) begin
            if (u.rx_active) saw_active = 1'b1;
            if (u.rx_valid || u.rx_error) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {30'd0, u.rx_valid, u.rx_error}, 32'd0);
                end else begin
                    mon_ev = exp_q.pop_front();
                    if (mon_ev.is_err) begin
                        check("error_strobe", {30'd0, u.rx_valid, u.rx_error}, 32'd1);
                    end else begin
                        check("valid_strobe", {30'd0, u.rx_valid, u.rx_error}, 32'd2);
                        check("rx_data", {24'd0, u.rx_data}, {24'd0, mon_ev.data});
                    end
                end
            end
        end
    end

    task automatic drive(input logic [1:0] ls, input int n);
        u.usb_d_p = ls[0];
        u.usb_d_n = ls[1];
        repeat (n) begin
            @(posedge clk48);
            #1;
        end
    endtask

    task automatic send_level(input logic [1:0] ls);
        int p;
        if (alt_mode) begin
            alt_ph = ~alt_ph;
            p = alt_ph ? 3 : 5;
        end else begin
            p = 4;
        end
        drive(ls, p);
    endtask

    // NRZI: a 0 toggles the line, a 1 holds it.
    task automatic send_bit(input bit b);
        if (!b) cur_k = ~cur_k;
        send_level(cur_k ? 2'b10 : 2'b01);
    endtask

    task automatic send_sync();
        cur_k = 1'b0;
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    task automatic send_eop();
        send_level(2'b00);
        send_level(2'b00);
        cur_k = 1'b0;
        send_level(2'b01);
        drive(2'b01, 40);
    endtask

    task automatic finish_packet(input string name);
        check({name, "_active_seen"}, {31'd0, saw_active}, 32'd1);
        check({name, "_active_low"}, {31'd0, u.rx_active}, 32'd0);
        saw_active = 1'b0;
    endtask

    // Whole bytes plus nx trailing bits, with a stuffed 0 after every six 1s.
    task automatic send_packet(input string name, input logic [7:0] bytes[$], input int nx,
                               input logic [7:0] xbits);
        bit bits[$];
        int ones = 0;
        bit b;
        saw_active = 1'b0;
        for (int i = 0; i < bytes.size(); i++) push_byte(bytes[i]);
        if (nx != 0) push_err();
        for (int i = 0; i < bytes.size() * 8 + nx; i++) begin
            b = (i < bytes.size() * 8) ? bytes[i / 8][i % 8] : xbits[i - bytes.size() * 8];
            bits.push_back(b);
            ones = b ? ones + 1 : 0;
            if (ones == 6) begin
                bits.push_back(1'b0);
                ones = 0;
            end
        end
        send_sync();
        foreach (bits[i]) send_bit(bits[i]);
        send_eop();
        finish_packet(name);
    endtask

    initial begin
        logic [7:0] bq[$];
        int rise, fall, n;
        bit act_bad;

        // Reset held with the pins toggling.
        u.usb_d_p = 1'b0;
        u.usb_d_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk48);
            #1;
            u.usb_d_p = 1'($urandom_range(0, 1));
            u.usb_d_n = 1'($urandom_range(0, 1));
            check("reset_outputs", 32'({u.rx_data, u.rx_valid, u.rx_active, u.rx_error,
                                        u.bus_reset, u.line_state}), 32'h0001);
        end
        u.usb_d_p = 1'b1;
        u.usb_d_n = 1'b0;
        rst_n = 1'b1;
        drive(2'b01, 100);
        check("idle_line_state", {30'd0, u.line_state}, 32'd1);
        check("idle_active", {31'd0, u.rx_active}, 32'd0);

        // Long SE0: bus_reset timing measured from the pin change.
        rise = -1;
        act_bad = 1'b0;
        u.usb_d_p = 1'b0;
        u.usb_d_n = 1'b0;
        for (int i = 1; i <= 480; i++) begin
            @(posedge clk48);
            #1;
            if (u.bus_reset && rise < 0) rise = i;
            if (u.rx_active) act_bad = 1'b1;
        end
        check("bus_reset_rise", rise, RESET_CYCLES + 2);
        check("se0_line_state", {30'd0, u.line_state}, 32'd0);
        fall = -1;
        u.usb_d_p = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk48);
            #1;
            if (!u.bus_reset && fall < 0) fall = i;
            if (u.rx_active) act_bad = 1'b1;
        end
        check("bus_reset_fall", fall, 3);
        check("bus_reset_no_active", {31'd0, act_bad}, 32'd0);
        drive(2'b01, 20);

        // Single byte, nominal timing.
        bq = '{8'hA5};
        send_packet("pkt_a5", bq, 0, 8'h00);

        // Stuffing inside 0xFF, then 0x00.
        bq = '{8'hFF, 8'h00};
        send_packet("pkt_ff00", bq, 0, 8'h00);

        // Seven 1s with no stuff bit, then a clean packet.
        saw_active = 1'b0;
        push_err();
        send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        send_eop();
        finish_packet("stuff_err");
        bq = '{8'h3C};
        send_packet("pkt_3c", bq, 0, 8'h00);

        // Alternating 3/5-cycle bits, EOP four bits into the second byte.
        alt_mode = 1'b1;
        bq = '{8'h5A};
        send_packet("pkt_5a_trunc", bq, 4, 8'h0A);
        alt_mode = 1'b0;

        // Randomised packets: length, content, bit timing, truncation.
        for (int k = 0; k < 24; k++) begin
            alt_mode = 1'($urandom_range(0, 1));
            bq = {};
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) bq.push_back(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) begin
                send_packet("rand_trunc", bq, $urandom_range(1, 7), 8'($urandom_range(0, 255)));
            end else begin
                send_packet("rand_pkt", bq, 0, 8'h00);
            end
        end
        alt_mode = 1'b0;

        drive(2'b01, 50);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
